kplic_int_cond: RTL and testbench

- Input conditioner for external interrupt sources, placed directly upstream of kplic.
- Takes raw asynchronous pins and passes them through per-source polarity normalisation, a multi-flop synchroniser and a programmable glitch filter.
- Drives kplic's external_int vector, so each kplic_gateway sees clean, active-high, kplic_clk-synchronous levels.
- Configuration inputs are quasi-static and come from the platform register block.

---
 rtl/kplic_int_cond_pkg.sv | 26 ++
 rtl/kplic_int_cond_if.sv | 21 ++
 rtl/kplic_int_filter.sv | 89 ++++++++
 rtl/kplic_int_cond.sv | 34 +++
 tb/tb_kplic_int_cond.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/kplic_int_cond_pkg.sv
// Shared defaults and filter decode types for the kplic external interrupt conditioner.
// Build switch: KPLIC_INT_COND_FILT_EN enables the per-source glitch filter.
`ifndef INT_NUM
`define INT_NUM 4
`endif
`ifndef KPLIC_FILT_W
`define KPLIC_FILT_W 4
`endif
`ifndef KPLIC_SYNC_STAGES
`define KPLIC_SYNC_STAGES 2
`endif

package kplic_int_cond_pkg;

  localparam int INT_NUM_DEF     = `INT_NUM;
  localparam int FILT_W_DEF      = `KPLIC_FILT_W;
  localparam int SYNC_STAGES_DEF = `KPLIC_SYNC_STAGES;

  // Per-cycle decision of one source's filter.
  typedef enum logic [1:0] {
    ACT_CLEAR = 2'd0,
    ACT_COUNT = 2'd1,
    ACT_TAKE  = 2'd2
  } filt_act_e;

endpackage

// File: rtl/kplic_int_cond_if.sv
// Pin/config/output bundle between the platform and kplic_int_cond.
interface kplic_int_cond_if #(
  parameter int INT_NUM = 4,
  parameter int FILT_W  = 4
);
  logic [INT_NUM-1:0] external_int_raw;
  logic [INT_NUM-1:0] int_polarity;
  logic [INT_NUM-1:0] filt_bypass;
  logic [FILT_W-1:0]  filt_len;
  logic [INT_NUM-1:0] external_int;

  modport master (
    output external_int_raw, int_polarity, filt_bypass, filt_len,
    input  external_int
  );

  modport slave (
    input  external_int_raw, int_polarity, filt_bypass, filt_len,
    output external_int
  );
endinterface

// File: rtl/kplic_int_filter.sv
// One interrupt source: polarity normalise, synchronise, optional glitch filter.
// Build switch: KPLIC_INT_COND_FILT_EN enables the counter; otherwise the source is always bypassed.
module kplic_int_filter
  import kplic_int_cond_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              raw,
  input  logic              polarity,
  input  logic              bypass,
  input  logic [FILT_W-1:0] len,
  output logic              int_out
);

  logic                   norm_s;
  logic                   sync_s;
  logic [SYNC_STAGES-1:0] sync_r;
  logic                   stable_r;

  // Normalising before the first flop keeps the reset value at the inactive level.
  assign norm_s  = raw ^ polarity;
  assign sync_s  = sync_r[SYNC_STAGES-1];
  assign int_out = stable_r;

  // Synchroniser chain for the asynchronous pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], norm_s};
    end
  end

`ifdef KPLIC_INT_COND_FILT_EN
  filt_act_e         act_s;
  logic [FILT_W-1:0] cnt_r;

  // Decide this cycle's filter action; >= lets a lowered length fire immediately.
  always_comb begin
    act_s = ACT_CLEAR;
    if (bypass) begin
      act_s = ACT_TAKE;
    end else if (sync_s == stable_r) begin
      act_s = ACT_CLEAR;
    end else if (cnt_r >= len) begin
      act_s = ACT_TAKE;
    end else begin
      act_s = ACT_COUNT;
    end
  end

  // Counter and stable level; cnt only increments while below len, so it never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_r <= 1'b0;
      cnt_r    <= {FILT_W{1'b0}};
    end else begin
      case (act_s)
        ACT_TAKE: begin
          stable_r <= sync_s;
          cnt_r    <= {FILT_W{1'b0}};
        end
        ACT_COUNT: begin
          cnt_r <= cnt_r + {{(FILT_W-1){1'b0}}, 1'b1};
        end
        default: begin
          cnt_r <= {FILT_W{1'b0}};
        end
      endcase
    end
  end
`else
  logic unused_s;
  assign unused_s = ^{bypass, len};

  // Without the filter every source follows the synchroniser output directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_r <= 1'b0;
    end else begin
      stable_r <= sync_s;
    end
  end
`endif

endmodule

// File: rtl/kplic_int_cond.sv
// kplic external interrupt conditioner: one independent filter per source feeding kplic.external_int.
// Build switch: KPLIC_INT_COND_FILT_EN selects the glitch-filtered build.
module kplic_int_cond
  import kplic_int_cond_pkg::*;
#(
  parameter int INT_NUM     = INT_NUM_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int FILT_W      = FILT_W_DEF
) (
  input  logic              kplic_clk,
  input  logic              kplic_rstn,
  kplic_int_cond_if.slave   bus
);

  logic [INT_NUM-1:0] ext_s;

  assign bus.external_int = ext_s;

  for (genvar i = 0; i < INT_NUM; i++) begin : g_src
    kplic_int_filter #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_W      (FILT_W)
    ) u_filter (
      .clk      (kplic_clk),
      .rst_n    (kplic_rstn),
      .raw      (bus.external_int_raw[i]),
      .polarity (bus.int_polarity[i]),
      .bypass   (bus.filt_bypass[i]),
      .len      (bus.filt_len),
      .int_out  (ext_s[i])
    );
  end

endmodule

// File: tb/tb_kplic_int_cond.sv
// Scoreboard bench for kplic_int_cond: expected output change events are queued, a monitor matches them.
module tb_kplic_int_cond;
  import kplic_int_cond_pkg::*;

  localparam int N  = INT_NUM_DEF;
  localparam int FW = FILT_W_DEF;
  localparam int SS = SYNC_STAGES_DEF;
`ifdef KPLIC_INT_COND_FILT_EN
  localparam bit FILT_EN = 1'b1;
`else
  localparam bit FILT_EN = 1'b0;
`endif

  typedef struct {
    int           cyc;
    logic [N-1:0] val;
  } ev_t;

  logic         clk;
  logic         rstn;
  int           cyc;
  int           n_cmp;
  int           n_bad;
  ev_t          exp_q[$];
  logic [N-1:0] exp_vec;
  logic [N-1:0] prev;

  kplic_int_cond_if #(.INT_NUM(N), .FILT_W(FW)) bus ();

  kplic_int_cond dut (
    .kplic_clk  (clk),
    .kplic_rstn (rstn),
    .bus        (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every change of external_int must match the next queued event.
  always @(negedge clk) begin
    if (bus.external_int !== prev) begin
      n_cmp = n_cmp + 1;
      if (exp_q.size() == 0) begin
        n_bad = n_bad + 1;
        $display("FAIL unexpected_change: got %b at cyc %0d, want no change", bus.external_int, cyc);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        if (e.val !== bus.external_int || e.cyc != cyc) begin
          n_bad = n_bad + 1;
          $display("FAIL event: got %b at cyc %0d, want %b at cyc %0d", bus.external_int, cyc, e.val, e.cyc);
        end
      end
      prev = bus.external_int;
    end
  end

  function automatic int lat(input int l, input bit byp);
    return (FILT_EN && !byp) ? (SS + 1 + l) : (SS + 1);
  endfunction

  function automatic bit passes(input int w, input int l, input bit byp);
    return !FILT_EN || byp || (w > l);
  endfunction

  task automatic expect_bit(input int at, input int idx, input logic v);
    exp_vec[idx] = v;
    exp_q.push_back('{at, exp_vec});
  endtask

  task automatic expect_all(input int at, input logic [N-1:0] v);
    exp_vec = v;
    exp_q.push_back('{at, exp_vec});
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string name);
    n_cmp = n_cmp + 1;
    if (bus.external_int !== {N{1'b0}}) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %b, want %b", name, bus.external_int, {N{1'b0}});
    end
  endtask

  task automatic glitch(input int idx, input int w, input int l);
    int k;
    k = cyc;
    bus.external_int_raw[idx] = 1'b1;
    if (passes(w, l, 1'b0)) begin
      expect_bit(k + lat(l, 1'b0), idx, 1'b1);
      expect_bit(k + w + lat(l, 1'b0), idx, 1'b0);
    end
    step(w);
    bus.external_int_raw[idx] = 1'b0;
    step(w + l + 10);
  endtask

  initial begin
    int k;
    cyc     = 0;
    n_cmp   = 0;
    n_bad   = 0;
    exp_vec = {N{1'b0}};
    prev    = {N{1'b0}};
    rstn    = 1'b0;
    bus.int_polarity     = {N{1'b0}};
    bus.external_int_raw = {N{1'b1}};
    bus.filt_bypass      = {N{1'b0}};
    bus.filt_len         = FW'(3);

    // Reset held with every pin at its active level.
    repeat (4) begin
      @(negedge clk);
      check_zero("reset_hold");
    end

    // Release with active-low idle pins: nothing may assert.
    bus.int_polarity = {N{1'b1}};
    step(1);
    rstn = 1'b1;
    step(20);
    @(negedge clk);
    check_zero("reset_idle");

    // Re-enter reset to set per-source polarity for the rest of the run.
    step(1);
    rstn = 1'b0;
    bus.int_polarity        = {N{1'b0}};
    bus.int_polarity[2]     = 1'b1;
    bus.external_int_raw    = {N{1'b0}};
    bus.external_int_raw[2] = 1'b1;
    step(2);
    rstn = 1'b1;
    step(3);

    // Filtered assert/deassert on source 0, L=3.
    k = cyc;
    bus.external_int_raw[0] = 1'b1;
    expect_bit(k + lat(3, 1'b0), 0, 1'b1);
    step(12);
    k = cyc;
    bus.external_int_raw[0] = 1'b0;
    expect_bit(k + lat(3, 1'b0), 0, 1'b0);
    step(12);

    // Glitch rejection on source 1.
    glitch(1, 3, 3);
    glitch(1, 4, 3);
    glitch(1, 1, 3);

    // Bypass plus active-low on source 2.
    bus.filt_bypass[2] = 1'b1;
    k = cyc;
    bus.external_int_raw[2] = 1'b0;
    expect_bit(k + lat(3, 1'b1), 2, 1'b1);
    step(8);
    k = cyc;
    bus.external_int_raw[2] = 1'b1;
    expect_bit(k + lat(3, 1'b1), 2, 1'b0);
    step(8);
    k = cyc;
    bus.external_int_raw[2] = 1'b0;
    expect_bit(k + lat(3, 1'b1), 2, 1'b1);
    expect_bit(k + 1 + lat(3, 1'b1), 2, 1'b0);
    step(1);
    bus.external_int_raw[2] = 1'b1;
    step(8);

    // Length lowered mid-count: cnt is 3 when L drops to 2, so the next edge fires.
    bus.filt_len = FW'(10);
    k = cyc;
    bus.external_int_raw[3] = 1'b1;
    expect_bit(FILT_EN ? (k + 6) : (k + lat(10, 1'b0)), 3, 1'b1);
    step(5);
    bus.filt_len = FW'(2);
    step(10);
    k = cyc;
    bus.external_int_raw[3] = 1'b0;
    expect_bit(k + lat(2, 1'b0), 3, 1'b0);
    step(12);

    // All sources together, L=0 then L=15.
    bus.filt_bypass = {N{1'b0}};
    bus.filt_len    = FW'(0);
    k = cyc;
    bus.external_int_raw = ~bus.external_int_raw;
    expect_all(k + lat(0, 1'b0), {N{1'b1}});
    step(8);
    bus.filt_len = FW'(15);
    k = cyc;
    bus.external_int_raw = ~bus.external_int_raw;
    expect_all(k + lat(15, 1'b0), {N{1'b0}});
    step(25);

    while (exp_q.size() != 0) begin
      ev_t e;
      e = exp_q.pop_front();
      n_cmp = n_cmp + 1;
      n_bad = n_bad + 1;
      $display("FAIL missing_event: got no change, want %b at cyc %0d", e.val, e.cyc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
